// File: rtl/nor_share_arb.sv
// rtl/nor_share_arb.sv - round-robin arbiter sharing one W-bit NOR unit among N requesters
module nor_share_arb #(
    parameter int IDW = 2,
    parameter int W   = 8,
    parameter int N   = 2**IDW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic [N*W-1:0]   a,
    input  logic [N*W-1:0]   b,
    output logic [N-1:0]     gnt,
    output logic             busy,
    output logic             res_valid,
    output logic [IDW-1:0]   res_id,
    output logic [W-1:0]     res
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   id;
    logic [W-1:0]     op_a;
    logic [W-1:0]     op_b;
    logic             found;
    logic [IDW-1:0]   win;
    logic [IDW-1:0]   idx;

    // Scan upward from ptr; IDW-bit addition gives the modulo-N wrap for free.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            idx = ptr + IDW'(k);
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (found) state_next = EVAL;
            EVAL:    state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr       <= '0;
            id        <= '0;
            op_a      <= '0;
            op_b      <= '0;
            gnt       <= '0;
            res_valid <= 1'b0;
            res_id    <= '0;
            res       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        op_a <= a[int'(win)*W +: W];
                        op_b <= b[int'(win)*W +: W];
                        id   <= win;
                        gnt  <= N'(1) << win;
                        ptr  <= win + IDW'(1);
                    end
                end
                EVAL: begin
                    res       <= ~(op_a | op_b);
                    res_id    <= id;
                    res_valid <= 1'b1;
                    gnt       <= '0;
                end
                DONE: begin
                    res_valid <= 1'b0;
                end
                default: begin
                    gnt       <= '0;
                    res_valid <= 1'b0;
                end
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule
